// File: rtl/narrow_pkg.sv
// rtl/narrow_pkg.sv - shared widths, limits and types for the 20->19 bit narrowing stage
package narrow_pkg;

    localparam int IN_W       = 20;
    localparam int OUT_W      = 19;
    localparam int MODE_SAT   = 0;
    localparam int MODE_HALVE = 1;

    localparam logic [OUT_W-1:0] MAX_OUT = 19'h7FFFF;

    // One buffered result: clamp flag travels with the narrowed value
    typedef struct packed {
        logic             sat;
        logic [OUT_W-1:0] data;
    } narrow_word_t;

endpackage

// File: rtl/skid_buf2.sv
// rtl/skid_buf2.sv - 2-entry valid/ready FIFO with registered full flag
module skid_buf2 #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic [1:0]   r_cnt;
    logic         r_full;

    logic         w_push;
    logic         w_pop;
    logic [1:0]   w_cnt_nxt;

    // in_ready depends only on the registered full flag, never on out_ready
    assign in_ready  = !r_full;
    assign out_valid = (r_cnt != 2'd0);
    assign out_data  = r_head;

    assign w_push = in_valid && !r_full;
    assign w_pop  = (r_cnt != 2'd0) && out_ready;

    // Occupancy after this edge's push/pop
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !w_pop) begin
            w_cnt_nxt = r_cnt + 2'd1;
        end else if (w_pop && !w_push) begin
            w_cnt_nxt = r_cnt - 2'd1;
        end
    end

    // Storage update: head is always the oldest word; head holds while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= 2'd0;
            r_full <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_full <= (w_cnt_nxt == 2'd2);
            if (w_pop) begin
                if (r_cnt == 2'd2) begin
                    r_head <= r_tail;
                end else if (w_push) begin
                    r_head <= in_data;
                end
            end else if (w_push) begin
                if (r_cnt == 2'd0) begin
                    r_head <= in_data;
                end else begin
                    r_tail <= in_data;
                end
            end
        end
    end

endmodule

// File: rtl/narrow20_19.sv
// rtl/narrow20_19.sv - narrows 20-bit adder sums to 19 bits by saturation or rounded halving
module narrow20_19
    import narrow_pkg::*;
#(
    parameter int MODE  = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:IN_W-1]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:OUT_W-1] out_data,
    output logic             out_sat,
    input  logic             clr_count,
    output logic [CNT_W-1:0] sat_count
);

    logic [IN_W:0]  w_sum;
    logic [IN_W:0]  w_half;
    narrow_word_t   w_word;
    narrow_word_t   w_head;
    logic           w_in_fire;
    logic [CNT_W-1:0] r_sat_count;

    // Round-half-up halving needs one extra bit so 20'hFFFFF + 1 does not wrap
    assign w_sum  = {1'b0, in_data} + 21'd1;
    assign w_half = w_sum >> 1;

    // Narrowing rule selected by MODE; only 20'hFFFFF overflows in halving mode
    always_comb begin
        w_word = '0;
        if (MODE == MODE_HALVE) begin
            if (w_half > {2'b00, MAX_OUT}) begin
                w_word.sat  = 1'b1;
                w_word.data = MAX_OUT;
            end else begin
                w_word.sat  = 1'b0;
                w_word.data = w_half[OUT_W-1:0];
            end
        end else begin
            if (in_data[0]) begin
                w_word.sat  = 1'b1;
                w_word.data = MAX_OUT;
            end else begin
                w_word.sat  = 1'b0;
                w_word.data = in_data[1:IN_W-1];
            end
        end
    end

    assign w_in_fire = in_valid && in_ready;

    skid_buf2 #(
        .W (OUT_W + 1)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_head)
    );

    assign out_data  = w_head.data;
    assign out_sat   = w_head.sat;
    assign sat_count = r_sat_count;

    // Sticky saturation counter: clear has priority, count sticks at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_count <= '0;
        end else if (clr_count) begin
            r_sat_count <= '0;
        end else if (w_in_fire && w_word.sat && (r_sat_count != {CNT_W{1'b1}})) begin
            r_sat_count <= r_sat_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_narrow20_19.sv
// tb/tb_narrow20_19.sv - scoreboard bench for narrow20_19 in both narrowing modes
module tb_narrow20_19;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [19:0] in_data;
    logic        out_ready;
    logic        clr_count;

    logic        in_ready0, out_valid0, out_sat0;
    logic [18:0] out_data0;
    logic [15:0] sat_count0;
    logic        in_ready1, out_valid1, out_sat1;
    logic [18:0] out_data1;
    logic [15:0] sat_count1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [19:0] q0[$];
    logic [19:0] q1[$];
    logic [15:0] m_cnt0, m_cnt1;
    logic        st0, st1;
    logic [19:0] held0, held1;

    always #5 clk = ~clk;

    narrow20_19 #(.MODE(0), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_sat(out_sat0), .clr_count(clr_count),
        .sat_count(sat_count0)
    );

    narrow20_19 #(.MODE(1), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_sat(out_sat1), .clr_count(clr_count),
        .sat_count(sat_count1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: {sat, result} from plain integer arithmetic
    function automatic logic [19:0] ref_narrow(input int mode, input logic [19:0] x);
        logic [31:0] t;
        if (mode == 0) t = {12'd0, x};
        else           t = ({12'd0, x} + 32'd1) / 32'd2;
        if (t > 32'h7FFFF) return {1'b1, 19'h7FFFF};
        return {1'b0, t[18:0]};
    endfunction

    function automatic logic [15:0] cnt_next(input logic [15:0] c, input logic clr,
                                             input logic fire, input logic sat);
        if (clr) return 16'd0;
        if (fire && sat && c != 16'hFFFF) return c + 16'd1;
        return c;
    endfunction

    // Monitor: compares outputs, stall stability and counter away from the active edge
    always @(negedge clk) begin
        logic [19:0] e0, e1;
        logic        fire;
        if (!rst_n) begin
            q0.delete(); q1.delete();
            m_cnt0 = 16'd0; m_cnt1 = 16'd0;
            st0 = 1'b0; st1 = 1'b0;
        end else begin
            chk("sat_count0", {16'd0, sat_count0}, {16'd0, m_cnt0});
            chk("sat_count1", {16'd0, sat_count1}, {16'd0, m_cnt1});
            if (st0) chk("stall_hold0", {12'd0, out_sat0, out_data0}, {12'd0, held0});
            if (st1) chk("stall_hold1", {12'd0, out_sat1, out_data1}, {12'd0, held1});
            if (out_valid0 && out_ready) begin
                if (q0.size() == 0) chk("unexpected_out0", 32'd1, 32'd0);
                else begin
                    e0 = q0.pop_front();
                    chk("out0", {12'd0, out_sat0, out_data0}, {12'd0, e0});
                end
            end
            if (out_valid1 && out_ready) begin
                if (q1.size() == 0) chk("unexpected_out1", 32'd1, 32'd0);
                else begin
                    e1 = q1.pop_front();
                    chk("out1", {12'd0, out_sat1, out_data1}, {12'd0, e1});
                end
            end
            st0 = out_valid0 && !out_ready; held0 = {out_sat0, out_data0};
            st1 = out_valid1 && !out_ready; held1 = {out_sat1, out_data1};
            fire = in_valid && in_ready0;
            e0 = ref_narrow(0, in_data);
            e1 = ref_narrow(1, in_data);
            if (fire) begin
                q0.push_back(e0);
                q1.push_back(e1);
            end
            m_cnt0 = cnt_next(m_cnt0, clr_count, fire, e0[19]);
            m_cnt1 = cnt_next(m_cnt1, clr_count, fire, e1[19]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [19:0] d0[4] = '{20'h00005, 20'h7FFFF, 20'h80000, 20'hFFFFF};
    logic [19:0] x0[4] = '{20'h00005, 20'h7FFFF, 20'hFFFFF, 20'hFFFFF};
    logic [19:0] d1[4] = '{20'h00003, 20'h00004, 20'hFFFFE, 20'hFFFFF};
    logic [19:0] x1[4] = '{20'h00002, 20'h00002, 20'h7FFFF, 20'hFFFFF};

    initial begin
        int          acc;
        int          cyc;
        int          r;
        logic [18:0] snap;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_count = 1'b0;
        tick(); tick();
        chk("rst_in_ready",  {31'd0, in_ready0},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid0}, 32'd0);
        chk("rst_out_data",  {13'd0, out_data0},  32'd0);
        chk("rst_out_sat",   {31'd0, out_sat0},   32'd0);
        chk("rst_sat_count", {16'd0, sat_count0}, 32'd0);
        chk("rst_out_valid1", {31'd0, out_valid1}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed saturate-mode words, one-cycle latency
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = d0[i];
            tick();
            chk("dir0_valid", {31'd0, out_valid0}, 32'd1);
            chk("dir0_word", {12'd0, out_sat0, out_data0}, {12'd0, x0[i]});
        end
        in_valid = 1'b0;
        tick();
        chk("dir0_sat_count", {16'd0, sat_count0}, 32'd2);

        // Directed halving-mode words
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = d1[i];
            tick();
            chk("dir1_valid", {31'd0, out_valid1}, 32'd1);
            chk("dir1_word", {12'd0, out_sat1, out_data1}, {12'd0, x1[i]});
        end
        in_valid = 1'b0;
        tick();

        // Backpressure: only two words fit, head stable
        out_ready = 1'b0; in_valid = 1'b1; acc = 0;
        for (int i = 0; i < 6; i++) begin
            in_data = $urandom & 20'hFFFFF;
            @(negedge clk);
            if (in_valid && in_ready0) acc++;
            if (i == 2) snap = out_data0;
            tick();
        end
        chk("bp_accepted", acc, 32'd2);
        chk("bp_in_ready", {31'd0, in_ready0}, 32'd0);
        chk("bp_head_stable", {13'd0, out_data0}, {13'd0, snap});
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick();
        chk("bp_drained", {31'd0, out_valid0}, 32'd0);

        // Random stalls, random data biased toward the saturation boundary
        acc = 0; cyc = 0;
        while (acc < 1000 && cyc < 20000) begin
            in_valid = ($urandom % 3) != 0;
            r = $urandom % 4;
            case (r)
                0: in_data = $urandom & 20'hFFFFF;
                1: in_data = 20'h7FFF8 + 20'($urandom % 16);
                2: in_data = 20'hFFFF0 + 20'($urandom % 16);
                default: in_data = 20'($urandom % 16);
            endcase
            out_ready = ($urandom % 3) != 0;
            clr_count = ($urandom % 50) == 0;
            @(negedge clk);
            if (in_valid && in_ready0) acc++;
            tick();
            cyc++;
        end
        chk("rand_accepted", acc, 32'd1000);
        in_valid = 1'b0; clr_count = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 10 && (q0.size() != 0 || q1.size() != 0); i++) tick();
        chk("rand_q0_empty", q0.size(), 32'd0);
        chk("rand_q1_empty", q1.size(), 32'd0);

        // Counter sticks at all-ones
        in_valid = 1'b1; in_data = 20'hFFFFF;
        repeat (65539) tick();
        in_valid = 1'b0;
        tick();
        chk("cnt_sat0", {16'd0, sat_count0}, 32'h0000FFFF);
        chk("cnt_sat1", {16'd0, sat_count1}, 32'h0000FFFF);

        // Clear beats a coincident increment
        in_valid = 1'b1; in_data = 20'hFFFFF; clr_count = 1'b1;
        tick();
        in_valid = 1'b0; clr_count = 1'b0;
        chk("clr_wins0", {16'd0, sat_count0}, 32'd0);
        chk("clr_wins1", {16'd0, sat_count1}, 32'd0);
        tick();

        // Asynchronous reset with two words buffered
        out_ready = 1'b0; in_valid = 1'b1; in_data = 20'hFFFFF;
        tick();
        in_data = 20'h00010;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid0", {31'd0, out_valid0}, 32'd0);
        chk("arst_out_valid1", {31'd0, out_valid1}, 32'd0);
        chk("arst_in_ready",   {31'd0, in_ready0},  32'd1);
        chk("arst_sat_count",  {16'd0, sat_count0}, 32'd0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 20'h00123; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("post_rst_valid", {31'd0, out_valid0}, 32'd1);
        chk("post_rst_data",  {13'd0, out_data0},  32'h00123);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/narrow20_19.md
# narrow20_19

Pipelined down-converter returning 20-bit adder-tree sums to the 19-bit datapath width used by the next neuron layer. Accepts one unsigned 20-bit sum per cycle over a valid/ready handshake and emits a 19-bit result using either saturation or rounded halving. Keeps a sticky saturation counter for training/debug readback. Sits directly downstream of each 19→20-bit adder stage.

## Interface
Parameters:
- MODE, 0: narrowing rule; 0 = saturate, 1 = shift right by one with round-half-up.
- CNT_W, 16: saturation counter width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept in_data this cycle.
- in_data  in  20  unsigned sum; index 0 is the MSB.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  19  narrowed result; index 0 is the MSB.
- out_sat  out  1  out_data was clamped; travels with out_data.
- clr_count  in  1  synchronous clear of sat_count.
- sat_count  out  CNT_W  number of accepted inputs that saturated.

## Operation
- Input handshake: transfer when in_valid && in_ready. Output handshake: transfer when out_valid && out_ready.
- MODE 0: if in_data > 19'h7FFFF, result = 19'h7FFFF and sat = 1; otherwise result = in_data[1:19], sat = 0.
- MODE 1: t = (in_data + 1) >> 1, computed in 21 bits. If t > 19'h7FFFF (only for in_data = 20'hFFFFF), result = 19'h7FFFF and sat = 1; otherwise result = t, sat = 0.
- Result and sat are computed combinationally from in_data and captured on input transfer into a 2-entry FIFO (skid buffer). out_data and out_sat come from the head entry.
- in_ready = buffer not full (fewer than 2 entries). The registered full flag drives in_ready; there is no combinational path from out_ready to in_ready.
- sat_count increments on each input transfer with sat = 1 and saturates at all-ones; it never wraps.
- clr_count: sat_count becomes 0 on the next edge. If clr_count coincides with an increment, clear wins and the result is 0.
- Simultaneous input and output transfer when full cannot occur, because in_ready = 0. When 1 entry is held, a simultaneous push and pop keeps the occupancy at 1, and the new word becomes the head.
- Input data is not examined when in_valid = 0. out_data holds its value while out_valid && !out_ready; no value changes while stalled.

## Timing
- Latency: a word accepted at edge N is presented with out_valid = 1 after edge N (visible in cycle N+1).
- Throughput is 1 word/cycle with out_ready held high. in_ready deasserts only after 2 words back up.
- Reset values: in_ready = 1, out_valid = 0, out_data = 0, out_sat = 0, sat_count = 0, buffer empty.
- Reset mid-operation: buffered words are discarded and the counter is zeroed immediately on rst_n low. No output transfer occurs during reset.

## Structure
- Package narrow_pkg holds:
  - IN_W = 20, OUT_W = 19
  - MAX_OUT = 19'h7FFFF
  - MODE_SAT = 0, MODE_HALVE = 1
- One sub-module, skid_buf2: a 2-entry valid/ready FIFO, OUT_W+1 bits wide. It is parameterised on width and reused later for other layer boundaries.
- Top level contains the narrowing logic, the counter, and the skid_buf2 instance.

## Test plan
- MODE 0, out_ready = 1, inputs 20'h00005, 20'h7FFFF, 20'h80000, 20'hFFFFF → outputs 19'h00005/0, 19'h7FFFF/0, 19'h7FFFF/1, 19'h7FFFF/1, one cycle later each; sat_count = 2.
- MODE 1, inputs 20'h00003, 20'h00004, 20'hFFFFE, 20'hFFFFF → outputs 19'h00002/0, 19'h00002/0, 19'h7FFFF/0, 19'h7FFFF/1.
- Backpressure: out_ready = 0 with continuous in_valid → exactly 2 words accepted, then in_ready = 0 and out_data stable. Raising out_ready drains them in order with no loss or duplication; a random-stall run of 1000 words matches the reference model.
- Counter: force 2^16+3 saturating inputs → sat_count holds at 16'hFFFF. clr_count asserted in the same cycle as a saturating input → sat_count = 0.
- Reset with 2 words buffered: drop rst_n asynchronously between edges → out_valid = 0, in_ready = 1, sat_count = 0 immediately. After release, the first new word appears with 1-cycle latency.
